// File: rtl/tile_barrier_pkg.sv
// Shared constants and helpers for the tile barrier tree node.
// Optional macro TILE_BARRIER_OUTPUT_REG_EN registers data_o.
package tile_barrier_pkg;

  localparam int BARR_P  = 0;
  localparam int BARR_W  = 1;
  localparam int BARR_E  = 2;
  localparam int BARR_N  = 3;
  localparam int BARR_S  = 4;
  localparam int BARR_RW = 5;
  localparam int BARR_RE = 6;

  localparam int barr_dirs_default = 7;

  // Any dest index at or above the direction count marks the root.
  localparam int BARR_ROOT = barr_dirs_default;

  function automatic int lg_dirs(int dirs);
    int w;
    w = $clog2(dirs + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/tile_barrier_if.sv
// Barrier flag bundle between a tree node and its tile neighbours.
// Optional macro TILE_BARRIER_OUTPUT_REG_EN does not affect this file.
interface tile_barrier_if
  import tile_barrier_pkg::*;
#(
    parameter int dirs_p = barr_dirs_default
);

    localparam int lg_dirs_lp = lg_dirs(dirs_p);

    logic [dirs_p-1:0]     data_i;
    logic [dirs_p-1:0]     data_o;
    logic [dirs_p-1:0]     src_r_i;
    logic [lg_dirs_lp-1:0] dest_r_i;

    modport master (
        output data_i,
        output src_r_i,
        output dest_r_i,
        input  data_o
    );

    modport slave (
        input  data_i,
        input  src_r_i,
        input  dest_r_i,
        output data_o
    );

endinterface

// File: rtl/tile_barrier_gather.sv
// Combinational sense-reversing gather of the participating child flags.
// Optional macro TILE_BARRIER_OUTPUT_REG_EN does not affect this file.
module tile_barrier_gather
  import tile_barrier_pkg::*;
#(
    parameter int dirs_p = barr_dirs_default
) (
    input  logic [dirs_p-1:0] data_r,
    input  logic [dirs_p-1:0] src_r,
    input  logic              sense_r,
    output logic              gather
);

    logic all_set;
    logic all_clr;

    // Non-participants read as "done" in both phases.
    assign all_set = &(data_r | ~src_r);
    assign all_clr = ~|(data_r & src_r);

    assign gather = sense_r ? ~all_clr : all_set;

endmodule

// File: rtl/tile_barrier_node.sv
// One node of the sense-reversing barrier tree, one per compute tile.
// Define TILE_BARRIER_OUTPUT_REG_EN to drive data_o from a register.
module tile_barrier_node
  import tile_barrier_pkg::*;
#(
    parameter int dirs_p = barr_dirs_default
) (
    input logic           clk_i,
    input logic           reset_n_i,
    tile_barrier_if.slave bus
);

    localparam int lg_dirs_lp = lg_dirs(dirs_p);

    logic [dirs_p-1:0]     data_r;
    logic                  sense_r;
    logic                  sense_n;
    logic                  gather;
    logic                  is_root;
    logic [lg_dirs_lp-1:0] dest;
    logic [dirs_p-1:0]     out_c;

    assign dest    = bus.dest_r_i;
    assign is_root = 32'(dest) >= dirs_p;

    tile_barrier_gather #(
        .dirs_p(dirs_p)
    ) u_gather (
        .data_r (data_r),
        .src_r  (bus.src_r_i),
        .sense_r(sense_r),
        .gather (gather)
    );

    // The root closes the loop itself; others follow the parent's release.
    always_comb begin
        sense_n = gather;
        if (!is_root) begin
            sense_n = data_r[dest];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            data_r  <= '0;
            sense_r <= 1'b0;
        end else begin
            data_r  <= bus.data_i;
            sense_r <= sense_n;
        end
    end

    // The upward gather overrides any src bit at the parent index.
    always_comb begin
        out_c = '0;
        if (reset_n_i) begin
            out_c = bus.src_r_i & {dirs_p{sense_r}};
            if (!is_root) begin
                out_c[dest] = gather;
            end
        end
    end

`ifdef TILE_BARRIER_OUTPUT_REG_EN
    logic [dirs_p-1:0] out_r;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            out_r <= '0;
        end else begin
            out_r <= out_c;
        end
    end

    assign bus.data_o = out_r;
`else
    assign bus.data_o = out_c;
`endif

endmodule

// File: tb/tb_tile_barrier_node.sv
// Directed self-checking bench for tile_barrier_node.
// Latencies track TILE_BARRIER_OUTPUT_REG_EN when it is defined.
module tb_tile_barrier_node;
    import tile_barrier_pkg::*;

`ifdef TILE_BARRIER_OUTPUT_REG_EN
    localparam int xl = 1;
`else
    localparam int xl = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int fails = 0;

    tile_barrier_if #(.dirs_p(7)) bus ();

    tile_barrier_node #(.dirs_p(7)) dut (
        .clk_i    (clk),
        .reset_n_i(rst_n),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic setup(input logic [6:0] src, input logic [2:0] dest, input logic [6:0] din);
        bus.src_r_i  = src;
        bus.dest_r_i = dest;
        bus.data_i   = din;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.data_i = '0;
        step(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        setup(7'b0000011, 3'(BARR_ROOT), 7'h7F);
        rst_n = 1'b0;
        step(2);
        checks++;
        if (bus.data_o !== 7'h00) begin
            fails++;
            $display("FAIL rst_hold_out got=%b exp=%b", bus.data_o, 7'h00);
        end
        checks++;
        if (dut.sense_r !== 1'b0) begin
            fails++;
            $display("FAIL rst_hold_sense got=%b exp=0", dut.sense_r);
        end
        rst_n = 1'b1;
        step(1);
        checks++;
        if (bus.data_o !== 7'h00) begin
            fails++;
            $display("FAIL rst_rel_out got=%b exp=%b", bus.data_o, 7'h00);
        end
        checks++;
        if (dut.sense_r !== 1'b0) begin
            fails++;
            $display("FAIL rst_rel_sense got=%b exp=0", dut.sense_r);
        end
        step(1);
        checks++;
        if (dut.sense_r !== 1'b1) begin
            fails++;
            $display("FAIL rst_sense_rise got=%b exp=1", dut.sense_r);
        end
    endtask

    task automatic test_root();
        setup(7'b0000011, 3'(BARR_ROOT), 7'b0000000);
        do_reset();
        bus.data_i = 7'b0000001;
        step(3);
        checks++;
        if (bus.data_o !== 7'b0000000) begin
            fails++;
            $display("FAIL root_partial got=%b exp=%b", bus.data_o, 7'b0000000);
        end
        bus.data_i = 7'b0000011;
        step(1 + xl);
        checks++;
        if (bus.data_o !== 7'b0000000) begin
            fails++;
            $display("FAIL root_rise_early got=%b exp=%b", bus.data_o, 7'b0000000);
        end
        step(1);
        checks++;
        if (bus.data_o !== 7'b0000011) begin
            fails++;
            $display("FAIL root_rise got=%b exp=%b", bus.data_o, 7'b0000011);
        end
        bus.data_i = 7'b0000000;
        step(1 + xl);
        checks++;
        if (bus.data_o !== 7'b0000011) begin
            fails++;
            $display("FAIL root_fall_early got=%b exp=%b", bus.data_o, 7'b0000011);
        end
        step(1);
        checks++;
        if (bus.data_o !== 7'b0000000) begin
            fails++;
            $display("FAIL root_fall got=%b exp=%b", bus.data_o, 7'b0000000);
        end
    endtask

    task automatic test_masked();
        setup(7'b0000011, 3'(BARR_ROOT), 7'b0000000);
        do_reset();
        bus.data_i = 7'b1111100;
        step(3);
        checks++;
        if (bus.data_o !== 7'b0000000) begin
            fails++;
            $display("FAIL masked_out got=%b exp=%b", bus.data_o, 7'b0000000);
        end
        checks++;
        if (dut.sense_r !== 1'b0) begin
            fails++;
            $display("FAIL masked_sense got=%b exp=0", dut.sense_r);
        end
    endtask

    task automatic test_nonroot();
        setup(7'b0000001, 3'(BARR_E), 7'b0000000);
        do_reset();
        bus.data_i = 7'b0000001;
        step(xl);
        checks++;
        if (bus.data_o !== 7'b0000000) begin
            fails++;
            $display("FAIL nr_up_early got=%b exp=%b", bus.data_o, 7'b0000000);
        end
        step(1);
        checks++;
        if (bus.data_o !== 7'b0000100) begin
            fails++;
            $display("FAIL nr_up got=%b exp=%b", bus.data_o, 7'b0000100);
        end
        bus.data_i = 7'b0000101;
        step(1 + xl);
        checks++;
        if (bus.data_o !== 7'b0000100) begin
            fails++;
            $display("FAIL nr_down_early got=%b exp=%b", bus.data_o, 7'b0000100);
        end
        step(1);
        checks++;
        if (bus.data_o !== 7'b0000101) begin
            fails++;
            $display("FAIL nr_down got=%b exp=%b", bus.data_o, 7'b0000101);
        end
        bus.data_i = 7'b0000100;
        step(1 + xl);
        checks++;
        if (bus.data_o !== 7'b0000001) begin
            fails++;
            $display("FAIL nr_child_clr got=%b exp=%b", bus.data_o, 7'b0000001);
        end
    endtask

    task automatic test_empty();
        logic exp_sense;
        setup(7'b0000000, 3'(BARR_ROOT), 7'b0000000);
        do_reset();
        exp_sense = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            exp_sense = ~exp_sense;
            checks++;
            if (bus.data_o !== 7'b0000000) begin
                fails++;
                $display("FAIL empty_out[%0d] got=%b exp=%b", i, bus.data_o, 7'b0000000);
            end
            checks++;
            if (dut.sense_r !== exp_sense) begin
                fails++;
                $display("FAIL empty_sense[%0d] got=%b exp=%b", i, dut.sense_r, exp_sense);
            end
        end
    endtask

    task automatic test_mid_reset();
        setup(7'b0000011, 3'(BARR_ROOT), 7'b0000000);
        do_reset();
        bus.data_i = 7'b0000001;
        step(2);
        rst_n = 1'b0;
        step(1);
        checks++;
        if (bus.data_o !== 7'b0000000) begin
            fails++;
            $display("FAIL mid_rst_out got=%b exp=%b", bus.data_o, 7'b0000000);
        end
        checks++;
        if (dut.sense_r !== 1'b0) begin
            fails++;
            $display("FAIL mid_rst_sense got=%b exp=0", dut.sense_r);
        end
        rst_n = 1'b1;
        bus.data_i = 7'b0000011;
        step(1 + xl);
        checks++;
        if (bus.data_o !== 7'b0000000) begin
            fails++;
            $display("FAIL mid_rel_early got=%b exp=%b", bus.data_o, 7'b0000000);
        end
        step(1);
        checks++;
        if (bus.data_o !== 7'b0000011) begin
            fails++;
            $display("FAIL mid_rel got=%b exp=%b", bus.data_o, 7'b0000011);
        end
    endtask

    initial begin
        setup(7'b0000000, 3'(BARR_ROOT), 7'b0000000);
        test_reset();
        test_root();
        test_masked();
        test_nonroot();
        test_empty();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
